// File: rtl/biriscv_csr_writeback.sv
// biriscv_csr_writeback: CSR commit stage for the biRISC-V pipeline.
// Carries the E1 CSR result through E2 and merges in late LSU faults there.
// Each entry then drives the csr_writeback_* bundle from WB for exactly one cycle.
// Nothing younger than a trapping entry is allowed to commit.
module biriscv_csr_writeback #(
   parameter int SUPPORT_LSU_FAULT = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        e1_valid_i,
   input  logic [31:0] e1_opcode_i,
   input  logic [31:0] e1_pc_i,
   input  logic        e1_csr_write_i,
   input  logic [31:0] e1_csr_wdata_i,
   input  logic [31:0] e1_value_i,
   input  logic [5:0]  e1_exception_i,
   input  logic [5:0]  e2_lsu_exception_i,
   input  logic [31:0] e2_lsu_addr_i,
   input  logic        stall_i,
   input  logic        squash_e1_i,
   output logic        csr_writeback_write_o,
   output logic [11:0] csr_writeback_waddr_o,
   output logic [31:0] csr_writeback_wdata_o,
   output logic [5:0]  csr_writeback_exception_o,
   output logic [31:0] csr_writeback_exception_pc_o,
   output logic [31:0] csr_writeback_exception_addr_o,
   output logic        csr_busy_o,
   output logic        flush_o
);

   // biRISC-V exception codes that select a non-zero trap value
   localparam logic [5:0] EXC_ILLEGAL_INSTRUCTION = 6'h12;
   localparam logic [5:0] EXC_BREAKPOINT          = 6'h13;
   localparam logic [5:0] EXC_MISALIGNED_LOAD     = 6'h14;
   localparam logic [5:0] EXC_FAULT_LOAD          = 6'h15;
   localparam logic [5:0] EXC_MISALIGNED_STORE    = 6'h16;
   localparam logic [5:0] EXC_FAULT_STORE         = 6'h17;
   localparam logic [5:0] EXC_PAGE_FAULT_LOAD     = 6'h1d;
   localparam logic [5:0] EXC_PAGE_FAULT_STORE    = 6'h1f;

   // In E2, tval holds the raw E1 value. The final trap value is resolved on the E2->WB move.
   typedef struct packed {
      logic        valid;
      logic        write;
      logic [11:0] waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [5:0]  exception;
      logic [31:0] tval;
   } entry_t;

   entry_t e1_entry;
   entry_t merged;
   entry_t e2_d, e2_q;
   entry_t wb_d, wb_q;
   logic   kill;
   logic   accept;

   // Only the CSR address field of the opcode is needed here
   logic unused_opcode_bits;
   assign unused_opcode_bits = ^e1_opcode_i[19:0];

   // Trap in WB, or a trapping entry about to leave E2, blocks younger entries
   assign flush_o = wb_q.valid & (wb_q.exception != 6'd0);
   assign kill    = (e2_q.valid & (e2_q.exception != 6'd0) & ~stall_i) | flush_o;
   assign accept  = e1_valid_i & ~stall_i & ~squash_e1_i & ~kill;

   // Package the E1 result as an entry
   always_comb begin
      e1_entry           = '0;
      e1_entry.valid     = 1'b1;
      e1_entry.write     = e1_csr_write_i;
      e1_entry.waddr     = e1_opcode_i[31:20];
      e1_entry.wdata     = e1_csr_wdata_i;
      e1_entry.pc        = e1_pc_i;
      e1_entry.exception = e1_exception_i;
      e1_entry.tval      = e1_value_i;
   end

   // Merge the late LSU fault, suppress the write on any trap, and pick the trap value
   always_comb begin
      // NOTE: every field gets a default first so this block can never infer a latch.
      merged = e2_q;
      if (SUPPORT_LSU_FAULT != 0 && e2_q.valid && e2_q.exception == 6'd0)
         merged.exception = e2_lsu_exception_i;
      merged.write = e2_q.write & (merged.exception == 6'd0);
      case (merged.exception)
         EXC_ILLEGAL_INSTRUCTION: merged.tval = e2_q.tval;
         EXC_BREAKPOINT:          merged.tval = e2_q.pc;
         EXC_MISALIGNED_LOAD,
         EXC_FAULT_LOAD,
         EXC_MISALIGNED_STORE,
         EXC_FAULT_STORE,
         EXC_PAGE_FAULT_LOAD,
         EXC_PAGE_FAULT_STORE:    merged.tval = e2_lsu_addr_i;
         default:                 merged.tval = 32'd0;
      endcase
   end

   // Next-state selection for E2 (flush > hold > accept > bubble) and WB (bubble on stall/flush)
   always_comb begin
      if (flush_o)
         e2_d = '0;
      else if (stall_i)
         e2_d = e2_q;
      else if (accept)
         e2_d = e1_entry;
      else
         e2_d = '0;

      // A stalled WB goes empty so that no entry pulses twice.
      // A flushing WB goes empty so that the entry behind a trap never commits.
      wb_d = (stall_i | flush_o) ? entry_t'('0) : merged;
   end

   // Pipeline registers with synchronous reset that drops in-flight entries
   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample together.
      if (rst_i) begin
         e2_q <= '0;
         wb_q <= '0;
      end else begin
         e2_q <= e2_d;
         wb_q <= wb_d;
      end
   end

   // The committed bundle comes straight from WB and is gated by valid
   assign csr_writeback_write_o          = wb_q.valid & wb_q.write;
   assign csr_writeback_waddr_o          = wb_q.valid ? wb_q.waddr     : 12'd0;
   assign csr_writeback_wdata_o          = wb_q.valid ? wb_q.wdata     : 32'd0;
   assign csr_writeback_exception_o      = wb_q.valid ? wb_q.exception : 6'd0;
   assign csr_writeback_exception_pc_o   = wb_q.valid ? wb_q.pc        : 32'd0;
   assign csr_writeback_exception_addr_o = wb_q.valid ? wb_q.tval      : 32'd0;
   assign csr_busy_o = (e2_q.valid & e2_q.write) | (wb_q.valid & wb_q.write);

endmodule

// File: tb/tb_biriscv_csr_writeback.sv
// tb_biriscv_csr_writeback: directed checks of the CSR commit stage.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_biriscv_csr_writeback;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        e1_valid_i;
   logic [31:0] e1_opcode_i;
   logic [31:0] e1_pc_i;
   logic        e1_csr_write_i;
   logic [31:0] e1_csr_wdata_i;
   logic [31:0] e1_value_i;
   logic [5:0]  e1_exception_i;
   logic [5:0]  e2_lsu_exception_i;
   logic [31:0] e2_lsu_addr_i;
   logic        stall_i;
   logic        squash_e1_i;
   logic        csr_writeback_write_o;
   logic [11:0] csr_writeback_waddr_o;
   logic [31:0] csr_writeback_wdata_o;
   logic [5:0]  csr_writeback_exception_o;
   logic [31:0] csr_writeback_exception_pc_o;
   logic [31:0] csr_writeback_exception_addr_o;
   logic        csr_busy_o;
   logic        flush_o;

   int checks = 0;
   int errors = 0;

   biriscv_csr_writeback #(.SUPPORT_LSU_FAULT(1)) dut (
      .clk_i                          (clk_i),
      .rst_i                          (rst_i),
      .e1_valid_i                     (e1_valid_i),
      .e1_opcode_i                    (e1_opcode_i),
      .e1_pc_i                        (e1_pc_i),
      .e1_csr_write_i                 (e1_csr_write_i),
      .e1_csr_wdata_i                 (e1_csr_wdata_i),
      .e1_value_i                     (e1_value_i),
      .e1_exception_i                 (e1_exception_i),
      .e2_lsu_exception_i             (e2_lsu_exception_i),
      .e2_lsu_addr_i                  (e2_lsu_addr_i),
      .stall_i                        (stall_i),
      .squash_e1_i                    (squash_e1_i),
      .csr_writeback_write_o          (csr_writeback_write_o),
      .csr_writeback_waddr_o          (csr_writeback_waddr_o),
      .csr_writeback_wdata_o          (csr_writeback_wdata_o),
      .csr_writeback_exception_o      (csr_writeback_exception_o),
      .csr_writeback_exception_pc_o   (csr_writeback_exception_pc_o),
      .csr_writeback_exception_addr_o (csr_writeback_exception_addr_o),
      .csr_busy_o                     (csr_busy_o),
      .flush_o                        (flush_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_wb(input string tag, input logic w, input logic [11:0] a,
                            input logic [31:0] d, input logic [5:0] e, input logic [31:0] pc,
                            input logic [31:0] tv, input logic fl, input logic bz);
      check({tag, ".write"}, 32'(csr_writeback_write_o),          32'(w));
      check({tag, ".waddr"}, 32'(csr_writeback_waddr_o),          32'(a));
      check({tag, ".wdata"}, csr_writeback_wdata_o,               d);
      check({tag, ".exc"},   32'(csr_writeback_exception_o),      32'(e));
      check({tag, ".pc"},    csr_writeback_exception_pc_o,        pc);
      check({tag, ".tval"},  csr_writeback_exception_addr_o,      tv);
      check({tag, ".flush"}, 32'(flush_o),                        32'(fl));
      check({tag, ".busy"},  32'(csr_busy_o),                     32'(bz));
   endtask

   task automatic expect_idle(input string tag, input logic bz);
      expect_wb(tag, 1'b0, 12'h000, 32'h0, 6'h00, 32'h0, 32'h0, 1'b0, bz);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_e1(input logic [31:0] op, input logic [31:0] pc, input logic [31:0] wdata,
                           input logic [31:0] value, input logic wr, input logic [5:0] exc);
      e1_valid_i     = 1'b1;
      e1_opcode_i    = op;
      e1_pc_i        = pc;
      e1_csr_wdata_i = wdata;
      e1_value_i     = value;
      e1_csr_write_i = wr;
      e1_exception_i = exc;
   endtask

   task automatic clear_e1();
      e1_valid_i     = 1'b0;
      e1_opcode_i    = 32'h0;
      e1_pc_i        = 32'h0;
      e1_csr_wdata_i = 32'h0;
      e1_value_i     = 32'h0;
      e1_csr_write_i = 1'b0;
      e1_exception_i = 6'h00;
   endtask

   initial begin
      clear_e1();
      rst_i              = 1'b1;
      stall_i            = 1'b0;
      squash_e1_i        = 1'b0;
      e2_lsu_exception_i = 6'h00;
      e2_lsu_addr_i      = 32'h0;

      // Reset state
      tick();
      tick();
      rst_i = 1'b0;
      expect_idle("reset", 1'b0);

      // Basic write: csrrw x0, mscratch, x5
      drive_e1(32'h34029073, 32'h80000010, 32'hDEADBEEF, 32'h0, 1'b1, 6'h00);
      tick();
      clear_e1();
      expect_idle("basic_e2", 1'b1);
      tick();
      expect_wb("basic_wb", 1'b1, 12'h340, 32'hDEADBEEF, 6'h00, 32'h80000010, 32'h0, 1'b0, 1'b1);
      tick();
      expect_idle("basic_after", 1'b0);

      // Illegal instruction followed by a younger entry that must never commit
      drive_e1(32'h30029073, 32'h80000100, 32'h12345678, 32'hFFFFFFFF, 1'b1, 6'h12);
      tick();
      drive_e1(32'h34129073, 32'h80000104, 32'h55555555, 32'h0, 1'b1, 6'h00);
      expect_idle("illegal_e2", 1'b1);
      tick();
      expect_wb("illegal_wb", 1'b0, 12'h300, 32'h12345678, 6'h12, 32'h80000100, 32'hFFFFFFFF, 1'b1, 1'b0);
      tick();
      clear_e1();
      expect_idle("illegal_killed1", 1'b0);
      tick();
      expect_idle("illegal_killed2", 1'b0);

      // LSU load fault merged in E2
      drive_e1(32'h34029073, 32'h80000200, 32'hCAFEF00D, 32'h0, 1'b1, 6'h00);
      tick();
      clear_e1();
      e2_lsu_exception_i = 6'h15;
      e2_lsu_addr_i      = 32'h10000004;
      tick();
      e2_lsu_exception_i = 6'h00;
      e2_lsu_addr_i      = 32'h0;
      expect_wb("lsu_wb", 1'b0, 12'h340, 32'hCAFEF00D, 6'h15, 32'h80000200, 32'h10000004, 1'b1, 1'b0);
      tick();
      expect_idle("lsu_after", 1'b0);

      // Early illegal-instruction outranks the LSU fault
      drive_e1(32'h34029073, 32'h80000300, 32'h0BADF00D, 32'h0000ABCD, 1'b1, 6'h12);
      tick();
      clear_e1();
      e2_lsu_exception_i = 6'h15;
      e2_lsu_addr_i      = 32'h10000008;
      tick();
      e2_lsu_exception_i = 6'h00;
      e2_lsu_addr_i      = 32'h0;
      expect_wb("prio_wb", 1'b0, 12'h340, 32'h0BADF00D, 6'h12, 32'h80000300, 32'h0000ABCD, 1'b1, 1'b0);
      tick();
      expect_idle("prio_after", 1'b0);

      // Breakpoint takes the PC as its trap value
      drive_e1(32'h00100073, 32'h80000400, 32'h0, 32'h0, 1'b0, 6'h13);
      tick();
      clear_e1();
      tick();
      expect_wb("bkpt_wb", 1'b0, 12'h001, 32'h0, 6'h13, 32'h80000400, 32'h80000400, 1'b1, 1'b0);
      tick();
      expect_idle("bkpt_after", 1'b0);

      // Stall for 3 cycles; a squashed E1 entry is offered during the stall
      drive_e1(32'h34029073, 32'h80000500, 32'h11223344, 32'h0, 1'b1, 6'h00);
      tick();
      drive_e1(32'h34129073, 32'h80000504, 32'h99999999, 32'h0, 1'b1, 6'h00);
      squash_e1_i = 1'b1;
      stall_i     = 1'b1;
      tick();
      expect_idle("stall1", 1'b1);
      tick();
      expect_idle("stall2", 1'b1);
      tick();
      expect_idle("stall3", 1'b1);
      stall_i     = 1'b0;
      squash_e1_i = 1'b0;
      clear_e1();
      tick();
      expect_wb("stall_release", 1'b1, 12'h340, 32'h11223344, 6'h00, 32'h80000500, 32'h0, 1'b0, 1'b1);
      tick();
      expect_idle("stall_after", 1'b0);

      // Squash: no pulse, busy stays low
      drive_e1(32'h34029073, 32'h80000600, 32'h77777777, 32'h0, 1'b1, 6'h00);
      squash_e1_i = 1'b1;
      tick();
      squash_e1_i = 1'b0;
      clear_e1();
      expect_idle("squash_e2", 1'b0);
      tick();
      expect_idle("squash_wb", 1'b0);

      // Squash together with a trapping E2 entry (ecall): the trap still commits
      drive_e1(32'h00000073, 32'h80000700, 32'h0, 32'h0, 1'b0, 6'h18);
      tick();
      drive_e1(32'h34029073, 32'h80000704, 32'h66666666, 32'h0, 1'b1, 6'h00);
      squash_e1_i = 1'b1;
      tick();
      squash_e1_i = 1'b0;
      clear_e1();
      expect_wb("ecall_wb", 1'b0, 12'h000, 32'h0, 6'h18, 32'h80000700, 32'h0, 1'b1, 1'b0);
      tick();
      expect_idle("ecall_after", 1'b0);

      // Back-to-back commits on consecutive cycles
      drive_e1(32'h34029073, 32'h80000800, 32'h00000001, 32'h0, 1'b1, 6'h00);
      tick();
      drive_e1(32'h34129073, 32'h80000804, 32'h00000002, 32'h0, 1'b1, 6'h00);
      tick();
      clear_e1();
      expect_wb("b2b_first", 1'b1, 12'h340, 32'h00000001, 6'h00, 32'h80000800, 32'h0, 1'b0, 1'b1);
      tick();
      expect_wb("b2b_second", 1'b1, 12'h341, 32'h00000002, 6'h00, 32'h80000804, 32'h0, 1'b0, 1'b1);
      tick();
      expect_idle("b2b_after", 1'b0);

      // Reset with entries in both E2 and WB: both are dropped
      drive_e1(32'h34029073, 32'h80000900, 32'hAAAA0001, 32'h0, 1'b1, 6'h00);
      tick();
      drive_e1(32'h34129073, 32'h80000904, 32'hAAAA0002, 32'h0, 1'b1, 6'h00);
      tick();
      clear_e1();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      expect_idle("rst_mid", 1'b0);
      tick();
      expect_idle("rst_drop1", 1'b0);
      tick();
      expect_idle("rst_drop2", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
